divider_ctrl: RTL and testbench

Run/stop sequencer for the programmable clock divider that produces the slow sample clock from the 0.6 MHz system clock.
- Accepts a new half-period through a valid/ready handshake.
- Applies a new half-period only at a full output-period boundary, so clk_out never carries a truncated or glitched pulse.
- Supports continuous mode and counted-burst mode.
- Reports busy status and issues a done pulse.

---
 rtl/divider_ctrl.sv | 160 ++++++++++++++++
 tb/tb_divider_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_ctrl.sv
// Run/stop sequencer for the programmable sample-clock divider (clk_out = clk_in / (2*half)).
// Latency: first clk_out rise `half` cycles after start; new half-periods take effect at the next period boundary.
// Backpressure: cfg_ready drops while a config is pending and rises the cycle after it is applied.
module divider_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 15,
  parameter int BURST_W      = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clk_out,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [BURST_W-1:0] PER_ONE = BURST_W'(1);
  localparam logic [BURST_W-1:0] PER_MAX = {BURST_W{1'b1}};

  state_t               state_q, state_nx;
  logic [CNT_W-1:0]     cnt_q, cnt_nx;
  logic [BURST_W-1:0]   period_q, period_nx;
  logic [BURST_W-1:0]   burst_q, burst_nx;
  logic                 pend_vld_q, pend_vld_nx;
  logic [CNT_W-1:0]     pend_half_q, pend_half_nx;
  logic [CNT_W-1:0]     act_half_q, act_half_nx;
  logic                 clk_out_q, clk_out_nx;
  logic                 tick_q, tick_nx;
  logic                 busy_q, busy_nx;
  logic                 done_q, done_nx;

  logic                 cfg_xfer;
  logic [CNT_W-1:0]     cfg_half_fix;
  logic                 cnt_hit;
  logic [BURST_W-1:0]   period_inc;

  assign cfg_ready    = ~pend_vld_q;
  assign cfg_xfer     = cfg_valid & ~pend_vld_q;
  assign cfg_half_fix = (cfg_half == '0) ? CNT_ONE : cfg_half;
  assign cnt_hit      = (cnt_q == (act_half_q - CNT_ONE));
  assign period_inc   = (period_q == PER_MAX) ? period_q : (period_q + PER_ONE);

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Next-state and next-output logic: counting, period completion, config apply, burst/stop exit.
  always_comb begin
    state_nx     = state_q;
    cnt_nx       = cnt_q;
    period_nx    = period_q;
    burst_nx     = burst_q;
    pend_vld_nx  = pend_vld_q;
    pend_half_nx = pend_half_q;
    act_half_nx  = act_half_q;
    clk_out_nx   = clk_out_q;
    tick_nx      = 1'b0;
    done_nx      = 1'b0;

    // A held config can never be overwritten: cfg_ready is low while pending.
    if (cfg_xfer) begin
      pend_vld_nx  = 1'b1;
      pend_half_nx = cfg_half_fix;
    end

    case (state_q)
      ST_IDLE: begin
        clk_out_nx = 1'b0;
        cnt_nx     = '0;
        // No output period in flight, so a pending half can go live at once.
        if (pend_vld_q) begin
          act_half_nx = pend_half_q;
          pend_vld_nx = 1'b0;
        end
        if (start && !stop) begin
          state_nx  = ST_RUN;
          period_nx = '0;
          burst_nx  = burst_len;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (cnt_hit) begin
          cnt_nx     = '0;
          clk_out_nx = ~clk_out_q;
          if (!clk_out_q) begin
            tick_nx = 1'b1;
          end else begin
            // Falling edge closes a full period: the only safe point to retime.
            period_nx = period_inc;
            if (pend_vld_q) begin
              act_half_nx = pend_half_q;
              pend_vld_nx = 1'b0;
            end
            if (((burst_q != '0) && (period_inc == burst_q)) || (state_q == ST_DRAIN)) begin
              state_nx = ST_IDLE;
              done_nx  = 1'b1;
            end
          end
        end else begin
          cnt_nx = cnt_q + CNT_ONE;
        end
        // A stop that coincides with the burst-ending completion is absorbed by that exit.
        if ((state_q == ST_RUN) && stop && (state_nx == ST_RUN)) begin
          state_nx = ST_DRAIN;
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        clk_out_nx = 1'b0;
        cnt_nx     = '0;
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  // State and datapath registers with synchronous reset; reset aborts a run without done.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      burst_q     <= '0;
      pend_vld_q  <= 1'b0;
      pend_half_q <= '0;
      act_half_q  <= CNT_W'(DEFAULT_HALF);
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      period_q    <= period_nx;
      burst_q     <= burst_nx;
      pend_vld_q  <= pend_vld_nx;
      pend_half_q <= pend_half_nx;
      act_half_q  <= act_half_nx;
      clk_out_q   <= clk_out_nx;
      tick_q      <= tick_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: scoreboard of expected tick/fall/done cycles
// built from a period-level timeline model, plus directed and randomized runs.
// A free-running monitor pops the scoreboard whenever the DUT shows an event.
module tb_divider_ctrl;
  localparam int CNT_W    = 16;
  localparam int BURST_W  = 8;
  localparam int DEF_HALF = 15;

  logic               clk_in = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_half = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic               clk_out;
  logic               tick;
  logic               busy;
  logic               done;

  divider_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF_HALF), .BURST_W(BURST_W)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter: at a negedge, cyc equals the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int tick_q[$];
  int fall_q[$];
  int done_q[$];
  logic prev_clk = 1'b0;
  int cur_half = DEF_HALF;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every tick, clk_out fall and done must match the head of its queue.
  always @(negedge clk_in) begin
    if (tick === 1'b1) begin
      if (tick_q.size() == 0) chk("tick_unexpected", cyc, -1);
      else chk("tick_cycle", cyc, tick_q.pop_front());
    end
    if (prev_clk && (clk_out === 1'b0)) begin
      if (fall_q.size() == 0) chk("fall_unexpected", cyc, -1);
      else chk("fall_cycle", cyc, fall_q.pop_front());
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
    prev_clk <= (clk_out === 1'b1);
  end

  // Offer one config while idle; it goes live on the following edge.
  task automatic cfg_idle(input int raw);
    cfg_valid = 1'b1;
    cfg_half  = CNT_W'(raw);
    @(negedge clk_in);
    cfg_valid = 1'b0;
    cfg_half  = CNT_W'($urandom_range(20, 40));
    chk("cfg_ready_idle_pending", int'(cfg_ready), 0);
    @(negedge clk_in);
    chk("cfg_ready_idle_applied", int'(cfg_ready), 1);
    cur_half = (raw == 0) ? 1 : raw;
  endtask

  // One run from IDLE. Offsets are edges after the start edge; -1 disables that event.
  // Reference timeline: each period is low for h then high for h cycles; a config
  // accepted before a completion edge retimes the periods after it; a stop ends the
  // run at the first completion after it; a reset aborts with no done.
  task automatic run_seq(input int burst, input int stop_off, input int cfg_off,
                         input int cfg_raw, input int abort_off, input bit flood);
    int k, s, h, n, t, p, a, last, apply_f, rise, fall, newh;
    bit pend;
    k = cyc + 1;
    s = k;
    h = cur_half;
    n = 0;
    pend = (cfg_off >= 0);
    t = k + cfg_off;
    p = (stop_off >= 0) ? k + stop_off : -1;
    a = (abort_off >= 0) ? k + abort_off : -1;
    newh = (cfg_raw == 0) ? 1 : cfg_raw;
    apply_f = -1;
    last = -1;
    while (last < 0 && n < 1000) begin
      rise = s + h;
      fall = s + 2 * h;
      n++;
      if (a >= 0 && rise >= a) begin
        last = a;
      end else begin
        tick_q.push_back(rise);
        if (a >= 0 && fall >= a) begin
          fall_q.push_back(a);
          last = a;
        end else begin
          fall_q.push_back(fall);
          if (pend && apply_f < 0 && t < fall) begin
            apply_f = fall;
            h = newh;
          end
          if ((burst != 0 && n == burst) || (p >= 0 && p < fall)) begin
            done_q.push_back(fall);
            last = fall;
          end
          s = fall;
        end
      end
    end
    for (int e = k; e <= last + 2; e++) begin
      start     = (e == k);
      burst_len = (e == k) ? BURST_W'(burst) : BURST_W'($urandom);
      stop      = (e == p);
      reset     = (e == a);
      cfg_valid = pend && ((e == t) || (flood && e > t && e <= t + 3));
      cfg_half  = (pend && e == t) ? CNT_W'(cfg_raw) : CNT_W'($urandom_range(20, 40));
      @(negedge clk_in);
      if (e == k) chk("busy_after_start", int'(busy), 1);
      if (pend && e == t) chk("cfg_ready_pending", int'(cfg_ready), 0);
      if (apply_f >= 0 && e == apply_f - 1) chk("cfg_ready_before_apply", int'(cfg_ready), 0);
      if (e == apply_f) chk("cfg_ready_after_apply", int'(cfg_ready), 1);
      if (e == last) begin
        chk("busy_at_end", int'(busy), 0);
        chk("clk_out_at_end", int'(clk_out), 0);
      end
    end
    start = 1'b0;
    stop = 1'b0;
    reset = 1'b0;
    cfg_valid = 1'b0;
    cur_half = (a >= 0) ? DEF_HALF : (pend ? newh : cur_half);
  endtask

  initial begin
    int burst, cfg_off, stop_off;
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cfg_ready", int'(cfg_ready), 1);
    reset = 1'b0;
    @(negedge clk_in);

    // Default half, continuous; stop 3 cycles into the low half of the second period.
    run_seq(0, 33, -1, 0, -1, 1'b0);

    // start together with stop in IDLE must not launch a run.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    repeat (20) @(negedge clk_in);
    chk("start_stop_busy_later", int'(busy), 0);
    chk("start_stop_clk_out", int'(clk_out), 0);

    // Burst of 3 periods at half 2.
    cfg_idle(2);
    run_seq(3, -1, -1, 0, -1, 1'b0);

    // Mid-run change to half 5 during the high half, with extra offers while pending.
    cfg_idle(15);
    run_seq(3, -1, 20, 5, -1, 1'b1);

    // Zero half-period behaves as 1.
    cfg_idle(0);
    run_seq(4, -1, -1, 0, -1, 1'b0);

    // Reset during the high half, then confirm the default half is active again.
    cfg_idle(6);
    run_seq(0, -1, -1, 0, 8, 1'b0);
    @(negedge clk_in);
    chk("cfg_ready_after_abort", int'(cfg_ready), 1);
    run_seq(1, -1, -1, 0, -1, 1'b0);

    // Randomized runs.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) cfg_idle(int'($urandom_range(0, 6)));
      burst    = int'($urandom_range(1, 4));
      cfg_off  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2 * cur_half - 1)) : -1;
      stop_off = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * cur_half * burst)) : -1;
      run_seq(burst, stop_off, cfg_off, int'($urandom_range(0, 6)), -1, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end

    repeat (4) @(negedge clk_in);
    chk("tick_q_leftover", tick_q.size(), 0);
    chk("fall_q_leftover", fall_q.size(), 0);
    chk("done_q_leftover", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
